// File: rtl/debug_mem_arbiter.sv
// Arbitrates a single-port synchronous RAM between core accesses and debug command pulses.
// Optional build macro DEBUG_MEM_HALT_GATE_EN gates debug issue on cpu_halted.
module debug_mem_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              cpu_clk,
  input  logic              sys_rstn,
`ifdef DEBUG_MEM_HALT_GATE_EN
  input  logic              cpu_halted,
`endif
  input  logic              dbg_ce,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_rvalid,
  output logic              dbg_busy,
  output logic              dbg_overrun,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_rvalid,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    RDWAIT
  } state_t;

  state_t              state;
  logic                pend_we;
  logic [ADDR_W-1:0]   pend_addr;
  logic [DATA_W-1:0]   pend_wdata;

  logic [READ_LATENCY-1:0] tag_vld;
  logic [READ_LATENCY-1:0] tag_dbg;

  logic issue_gate;
  logic dbg_issue;
  logic rd_issue;
  logic tail_vld;
  logic tail_dbg;

`ifdef DEBUG_MEM_HALT_GATE_EN
  assign issue_gate = cpu_halted;
`else
  assign issue_gate = 1'b1;
`endif

  assign dbg_issue = (state == PEND) && issue_gate;
  // Core is held off while in reset so the RAM port shows its idle values.
  assign core_gnt  = core_req && !dbg_issue && sys_rstn;

  always_comb begin
    mem_ce    = dbg_issue || core_gnt;
    mem_we    = 1'b0;
    mem_addr  = core_addr;
    mem_wdata = core_wdata;
    if (dbg_issue) begin
      mem_we    = pend_we;
      mem_addr  = pend_addr;
      mem_wdata = pend_wdata;
    end else if (core_gnt) begin
      mem_we    = core_we;
    end
  end

  assign rd_issue    = mem_ce && !mem_we;
  assign tail_vld    = tag_vld[READ_LATENCY-1];
  assign tail_dbg    = tag_dbg[READ_LATENCY-1];
  assign core_rvalid = tail_vld && !tail_dbg;
  assign core_rdata  = mem_rdata;

  // Tag pipeline: one {valid, owner} stage per cycle of RAM read latency.
  always_ff @(posedge cpu_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      tag_vld <= '0;
      tag_dbg <= '0;
    end else begin
      tag_vld[0] <= rd_issue;
      tag_dbg[0] <= rd_issue && dbg_issue;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_dbg[i] <= tag_dbg[i-1];
      end
    end
  end

  always_ff @(posedge cpu_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state       <= IDLE;
      pend_we     <= 1'b0;
      pend_addr   <= '0;
      pend_wdata  <= '0;
      dbg_rdata   <= '0;
      dbg_rvalid  <= 1'b0;
      dbg_busy    <= 1'b0;
      dbg_overrun <= 1'b0;
    end else begin
      dbg_rvalid <= 1'b0;
      if (dbg_ce && state != IDLE) begin
        dbg_overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (dbg_ce) begin
            pend_we    <= dbg_we;
            pend_addr  <= dbg_addr;
            pend_wdata <= dbg_wdata;
            state      <= PEND;
            dbg_busy   <= 1'b1;
          end
        end
        PEND: begin
          if (issue_gate) begin
            if (pend_we) begin
              state    <= IDLE;
              dbg_busy <= 1'b0;
            end else begin
              state    <= RDWAIT;
            end
          end
        end
        RDWAIT: begin
          if (tail_vld && tail_dbg) begin
            dbg_rdata  <= mem_rdata;
            dbg_rvalid <= 1'b1;
            state      <= IDLE;
            dbg_busy   <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          dbg_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_mem_arbiter.sv
// Scoreboarded directed bench for debug_mem_arbiter with a latency-accurate RAM model.
module tb_debug_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned RL = 2;

  logic          cpu_clk;
  logic          sys_rstn;
  logic          cpu_halted;
  logic          dbg_ce, dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata, dbg_rdata;
  logic          dbg_rvalid, dbg_busy, dbg_overrun;
  logic          core_req, core_we, core_gnt, core_rvalid;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata, core_rdata;
  logic          mem_ce, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  debug_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL)) dut (
    .cpu_clk    (cpu_clk),
    .sys_rstn   (sys_rstn),
`ifdef DEBUG_MEM_HALT_GATE_EN
    .cpu_halted (cpu_halted),
`endif
    .dbg_ce     (dbg_ce),
    .dbg_we     (dbg_we),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_rdata  (dbg_rdata),
    .dbg_rvalid (dbg_rvalid),
    .dbg_busy   (dbg_busy),
    .dbg_overrun(dbg_overrun),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_gnt   (core_gnt),
    .core_rdata (core_rdata),
    .core_rvalid(core_rvalid),
    .mem_ce     (mem_ce),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  int unsigned cyc = 0;
  always @(posedge cpu_clk) cyc <= cyc + 1;

  // RAM model: synchronous, read data valid RL cycles after issue.
  logic [DW-1:0] ram [0:255];
  logic [DW-1:0] rd_pipe [0:RL-1];
  always @(posedge cpu_clk) begin
    if (mem_ce && mem_we) ram[mem_addr[7:0]] <= mem_wdata;
    rd_pipe[0] <= (mem_ce && !mem_we) ? ram[mem_addr[7:0]] : 32'hBAD0_BAD0;
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[RL-1];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [DW-1:0] data;
    int unsigned   due;
  } exp_t;
  exp_t core_q[$];
  exp_t dbg_q[$];
  exp_t ce, de;

  always @(negedge cpu_clk) begin
    if (sys_rstn) begin
      if (core_rvalid) begin
        if (core_q.size() == 0) check("core_rvalid_unexpected", core_rvalid, 0);
        else begin
          ce = core_q.pop_front();
          check("core_rdata", core_rdata, ce.data);
          check("core_rvalid_cycle", cyc, ce.due);
        end
      end else if (core_q.size() != 0 && core_q[0].due < cyc) begin
        ce = core_q.pop_front();
        check("core_rvalid_missing", cyc, ce.due);
      end
      if (dbg_rvalid) begin
        if (dbg_q.size() == 0) check("dbg_rvalid_unexpected", dbg_rvalid, 0);
        else begin
          de = dbg_q.pop_front();
          check("dbg_rdata", dbg_rdata, de.data);
          check("dbg_rvalid_cycle", cyc, de.due);
        end
      end else if (dbg_q.size() != 0 && dbg_q[0].due < cyc) begin
        de = dbg_q.pop_front();
        check("dbg_rvalid_missing", cyc, de.due);
      end
    end
  end

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic idle_inputs();
    dbg_ce = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
  endtask

  int unsigned t0;

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'hA5A5_0000 | i;
    ram[8'h10] = 32'hCAFE_F00D;
    cpu_halted = 1'b1;
    idle_inputs();
    sys_rstn = 1'b0;
    repeat (3) tick();
    check("rst_dbg_rdata", dbg_rdata, 0);
    check("rst_dbg_rvalid", dbg_rvalid, 0);
    check("rst_dbg_busy", dbg_busy, 0);
    check("rst_dbg_overrun", dbg_overrun, 0);
    check("rst_core_rvalid", core_rvalid, 0);
    check("rst_mem_ce", mem_ce, 0);
    check("rst_mem_we", mem_we, 0);
    sys_rstn = 1'b1;
    repeat (2) tick();

    // Core-only read
    core_req = 1; core_addr = 32'h10; t0 = cyc;
    #1;
    check("core_gnt_alone", core_gnt, 1);
    check("core_mem_addr", mem_addr, 32'h10);
    core_q.push_back('{32'hCAFE_F00D, t0 + RL});
    tick(); core_req = 0;
    check("core_only_busy", dbg_busy, 0);
    repeat (RL + 2) tick();

    // Debug write with core held requesting (core write)
    dbg_ce = 1; dbg_we = 1; dbg_addr = 32'h20; dbg_wdata = 32'h1234_5678;
    core_req = 1; core_we = 1; core_addr = 32'h40; core_wdata = 32'h55;
    #1;
    check("wr_T_core_gnt", core_gnt, 1);
    tick(); dbg_ce = 0; dbg_we = 0;
    #1;
    check("wr_T1_mem_ce", mem_ce, 1);
    check("wr_T1_mem_we", mem_we, 1);
    check("wr_T1_mem_addr", mem_addr, 32'h20);
    check("wr_T1_mem_wdata", mem_wdata, 32'h1234_5678);
    check("wr_T1_core_gnt", core_gnt, 0);
    check("wr_T1_busy", dbg_busy, 1);
    tick();
    check("wr_T2_core_gnt", core_gnt, 1);
    check("wr_T2_busy", dbg_busy, 0);
    idle_inputs();
    repeat (2) tick();

    // Debug read, then a dropped pulse while waiting
    dbg_ce = 1; dbg_addr = 32'h20; t0 = cyc;
    dbg_q.push_back('{32'h1234_5678, t0 + 2 + RL});
    tick(); dbg_ce = 0;
    #1;
    check("rd_T1_mem_ce", mem_ce, 1);
    check("rd_T1_mem_we", mem_we, 0);
    check("rd_T1_mem_addr", mem_addr, 32'h20);
    tick(); dbg_ce = 1; dbg_addr = 32'h30;
    tick(); dbg_ce = 0;
    check("ovr_set", dbg_overrun, 1);
    check("ovr_no_issue", mem_ce, 0);
    while (cyc < t0 + 10) tick();
    check("rd_hold_rdata", dbg_rdata, 32'h1234_5678);
    check("ovr_sticky", dbg_overrun, 1);
    check("rd_queue_drained", dbg_q.size(), 0);

    // Interleave: simultaneous core read and debug capture
    dbg_ce = 1; dbg_addr = 32'h20;
    core_req = 1; core_addr = 32'h10; t0 = cyc;
    core_q.push_back('{32'hCAFE_F00D, t0 + RL});
    dbg_q.push_back('{32'h1234_5678, t0 + 2 + RL});
    #1;
    check("il_T_core_gnt", core_gnt, 1);
    check("il_T_mem_addr", mem_addr, 32'h10);
    tick(); dbg_ce = 0; core_addr = 32'h44;
    #1;
    check("il_T1_core_gnt", core_gnt, 0);
    check("il_T1_mem_addr", mem_addr, 32'h20);
    tick();
    check("il_T2_core_gnt", core_gnt, 1);
    check("il_T2_mem_addr", mem_addr, 32'h44);
    core_q.push_back('{32'hA5A5_0044, t0 + 2 + RL});
    tick(); idle_inputs();
    repeat (RL + 4) tick();

`ifdef DEBUG_MEM_HALT_GATE_EN
    cpu_halted = 0;
    dbg_ce = 1; dbg_we = 1; dbg_addr = 32'h50; dbg_wdata = 32'h77;
    tick(); dbg_ce = 0; dbg_we = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("gate_busy_held", dbg_busy, 1);
      check("gate_no_mem_ce", mem_ce, 0);
      tick();
    end
    cpu_halted = 1;
    #1;
    check("gate_open_mem_we", mem_we, 1);
    tick();
    check("gate_open_busy", dbg_busy, 0);
`endif

    // Reset while waiting for debug read data
    dbg_ce = 1; dbg_addr = 32'h10;
    tick(); dbg_ce = 0;
    tick();
    check("rst_mid_busy_before", dbg_busy, 1);
    sys_rstn = 0;
    #1;
    check("rst_mid_dbg_busy", dbg_busy, 0);
    check("rst_mid_dbg_rvalid", dbg_rvalid, 0);
    check("rst_mid_dbg_overrun", dbg_overrun, 0);
    check("rst_mid_dbg_rdata", dbg_rdata, 0);
    check("rst_mid_mem_ce", mem_ce, 0);
    check("rst_mid_core_rvalid", core_rvalid, 0);
    tick();
    sys_rstn = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("post_rst_no_dbg_rvalid", dbg_rvalid, 0);
    end

    t0 = cyc;
    while ((core_q.size() != 0 || dbg_q.size() != 0) && cyc < t0 + 50) tick();
    check("final_core_q_empty", core_q.size(), 0);
    check("final_dbg_q_empty", dbg_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
